// File: rtl/equ_samp_engine_pkg.sv
// Shared definitions for the equivalent-time sampling engine: command opcodes,
// FSM state encoding and status word bit positions.
package equ_samp_engine_pkg;

    localparam logic [3:0] OP_SET_BASE   = 4'd1;
    localparam logic [3:0] OP_SET_STEP   = 4'd2;
    localparam logic [3:0] OP_SET_NPTS   = 4'd3;
    localparam logic [3:0] OP_START      = 4'd4;
    localparam logic [3:0] OP_ABORT      = 4'd5;
    localparam logic [3:0] OP_SET_RDADDR = 4'd6;
    localparam logic [3:0] OP_SEL_STATUS = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_DELAY = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_STORE = 3'd5
    } state_e;

    localparam int STAT_BUSY = 31;
    localparam int STAT_DONE = 30;
    localparam int STAT_TMO  = 29;
    localparam int STAT_SAT  = 28;
    localparam int STAT_CONT = 27;

endpackage

// File: rtl/equ_samp_engine_dpram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module samp_dpram #(
    parameter int  ADC_W = 14,
    parameter int  DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [ADC_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [ADC_W-1:0] rdata_o
);

    logic [ADC_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/equ_samp_engine.sv
// Equivalent-time sampling engine: each synchronised trigger edge launches one
// ADC conversion after base+k*step cycles and stores the result at index k.
module equ_samp_engine
    import equ_samp_engine_pkg::*;
#(
    parameter int ADC_W   = 14,
    parameter int DEPTH   = 1024,
    parameter int DLY_W   = 20,
    parameter int START_W = 4,
    parameter int TMO_CYC = 256
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             trig_in,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [31:0]      cmd_word,
    input  logic             cmd_valid,
    output logic [31:0]      rd_value,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(((TMO_CYC > START_W) ? TMO_CYC : START_W) + 1);

    state_e            state_q, state_d;
    logic [2:0]        trig_sync_q, done_sync_q;
    logic              trig_edge_q, done_edge_q;
    logic [AW:0]       k_q, k_d, npts_q, npts_d, k_inc, npts_arg;
    logic [DLY_W-1:0]  acc_q, acc_d, cnt_q, cnt_d, base_q, base_d, step_q, step_d;
    logic [DLY_W:0]    acc_sum;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              cont_q, cont_d, done_q, done_d, tmo_q, tmo_d, sat_q, sat_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              sel_stat_q, sel_stat_d, we;
    logic [31:0]       rd_value_q, rd_value_d, status_w;
    logic [ADC_W-1:0]  ram_rdata;
    logic [3:0]        op;
    logic [27:0]       arg;
    logic              cmd_unused;

    function automatic logic [DLY_W:0] sat_add(input logic [DLY_W-1:0] a,
                                               input logic [DLY_W-1:0] b);
        logic [DLY_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[DLY_W]) begin
            s = {1'b1, {DLY_W{1'b1}}};
        end
        return s;
    endfunction

    assign op         = cmd_word[31:28];
    assign arg        = cmd_word[27:0];
    assign cmd_unused = ^cmd_word;
    assign busy       = (state_q != ST_IDLE);
    assign adc_start  = (state_q == ST_START);
    assign rd_value   = rd_value_q;
    assign k_inc      = k_q + (AW+1)'(1);
    assign acc_sum    = sat_add(acc_q, step_q);
    assign npts_arg   = arg[AW:0];
    assign status_w   = {busy, done_q, tmo_q, sat_q, cont_q, 11'b0, 16'(k_q)};

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        base_d     = base_q;
        step_d     = step_q;
        npts_d     = npts_q;
        cont_d     = cont_q;
        done_d     = done_q;
        tmo_d      = tmo_q;
        sat_d      = sat_q;
        rd_addr_d  = rd_addr_q;
        sel_stat_d = sel_stat_q;
        we         = 1'b0;

        if (cmd_valid && !busy) begin
            if (op == OP_SET_BASE) base_d = arg[DLY_W-1:0];
            if (op == OP_SET_STEP) step_d = arg[DLY_W-1:0];
            if (op == OP_SET_NPTS) begin
                npts_d = (npts_arg == '0 || npts_arg > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : npts_arg;
            end
        end
        if (cmd_valid && op == OP_SET_RDADDR) begin
            rd_addr_d  = arg[AW-1:0];
            sel_stat_d = 1'b0;
        end
        if (cmd_valid && op == OP_SEL_STATUS) sel_stat_d = 1'b1;

        if (cmd_valid && op == OP_ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cmd_valid && op == OP_START) begin
                    state_d = ST_ARM;
                    k_d     = '0;
                    acc_d   = base_q;
                    done_d  = 1'b0;
                    tmo_d   = 1'b0;
                    sat_d   = 1'b0;
                    cont_d  = arg[0];
                end
                // The edge cycle itself counts as one delay cycle, so DELAY is loaded with acc-2.
                ST_ARM: if (trig_edge_q) begin
                    if (acc_q <= DLY_W'(1)) begin
                        state_d = ST_START;
                        tmr_d   = TW'(START_W - 1);
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = acc_q - DLY_W'(2);
                    end
                end
                ST_DELAY: if (cnt_q == '0) begin
                    state_d = ST_START;
                    tmr_d   = TW'(START_W - 1);
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
                ST_START: if (tmr_q == '0) begin
                    state_d = ST_WAIT;
                    tmr_d   = TW'(TMO_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
                ST_WAIT: if (done_edge_q) begin
                    we      = 1'b1;
                    state_d = ST_STORE;
                end else if (tmr_q == '0) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
                ST_STORE: begin
                    k_d   = k_inc;
                    acc_d = acc_sum[DLY_W-1:0];
                    if (acc_sum[DLY_W]) sat_d = 1'b1;
                    if (k_inc < npts_q) begin
                        state_d = ST_ARM;
                    end else begin
                        done_d = 1'b1;
                        if (cont_q) begin
                            k_d     = '0;
                            acc_d   = base_q;
                            state_d = ST_ARM;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        rd_value_d = sel_stat_d ? status_w : 32'(ram_rdata);
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q     <= ST_IDLE;
            trig_sync_q <= '0;
            done_sync_q <= '0;
            trig_edge_q <= 1'b0;
            done_edge_q <= 1'b0;
            k_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            base_q      <= '0;
            step_q      <= DLY_W'(1);
            npts_q      <= (AW+1)'(DEPTH);
            cont_q      <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            sat_q       <= 1'b0;
            rd_addr_q   <= '0;
            sel_stat_q  <= 1'b0;
            rd_value_q  <= '0;
        end else begin
            state_q     <= state_d;
            trig_sync_q <= {trig_sync_q[1:0], trig_in};
            done_sync_q <= {done_sync_q[1:0], adc_done};
            trig_edge_q <= trig_sync_q[1] & ~trig_sync_q[2];
            done_edge_q <= done_sync_q[1] & ~done_sync_q[2];
            k_q         <= k_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            base_q      <= base_d;
            step_q      <= step_d;
            npts_q      <= npts_d;
            cont_q      <= cont_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            sat_q       <= sat_d;
            rd_addr_q   <= rd_addr_d;
            sel_stat_q  <= sel_stat_d;
            rd_value_q  <= rd_value_d;
        end
    end

    samp_dpram #(
        .ADC_W (ADC_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (k_q[AW-1:0]),
        .wdata_i (adc_data),
        .raddr_i (rd_addr_d),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_equ_samp_engine.sv
// Scoreboard bench for equ_samp_engine with a small buffer and short delay field.
module tb_equ_samp_engine;

    localparam int ADC_W   = 14;
    localparam int DEPTH   = 16;
    localparam int DLY_W   = 8;
    localparam int START_W = 4;
    localparam int TMO_CYC = 32;
    localparam int DMAX    = (1 << DLY_W) - 1;

    logic             clk = 1'b0;
    logic             rest = 1'b0;
    logic             trig_in = 1'b0;
    logic             adc_start;
    logic             adc_done = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic [31:0]      cmd_word = '0;
    logic             cmd_valid = 1'b0;
    logic [31:0]      rd_value;
    logic             busy;

    equ_samp_engine #(
        .ADC_W   (ADC_W),
        .DEPTH   (DEPTH),
        .DLY_W   (DLY_W),
        .START_W (START_W),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk       (clk),
        .rest      (rest),
        .trig_in   (trig_in),
        .adc_start (adc_start),
        .adc_done  (adc_done),
        .adc_data  (adc_data),
        .cmd_word  (cmd_word),
        .cmd_valid (cmd_valid),
        .rd_value  (rd_value),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int lat_q[$];
    logic [ADC_W-1:0] rb_q[$];

    logic [ADC_W-1:0] mem_m [DEPTH];
    int base_m, step_m, npts_m, k_m, acc_m, samp_n;
    bit cont_m, done_m, tmo_m, sat_m;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status(input bit b);
        return {b, done_m, tmo_m, sat_m, cont_m, 11'b0, 16'(k_m)};
    endfunction

    task automatic model_reset();
        base_m = 0; step_m = 1; npts_m = DEPTH; k_m = 0; acc_m = 0;
        cont_m = 0; done_m = 0; tmo_m = 0; sat_m = 0;
    endtask

    task automatic model_start(input bit c);
        k_m = 0; acc_m = base_m; done_m = 0; tmo_m = 0; sat_m = 0; cont_m = c;
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [27:0] arg);
        @(posedge clk);
        #1 cmd_word = {op, arg};
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic read_status(input string tag, input bit b);
        send_cmd(4'd7, 28'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq(tag, rd_value, model_status(b));
    endtask

    task automatic read_buf(input string tag, input int addr);
        rb_q.push_back(mem_m[addr]);
        send_cmd(4'd6, 28'(addr));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq(tag, rd_value, 32'(rb_q.pop_front()));
    endtask

    // Raise the trigger pin and wait for adc_start; latency is counted in clock edges from the pin.
    task automatic fire_trig(input string tag, input int extra_at);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        lat_q.push_back(((acc_m <= 1) ? 1 : acc_m) + 3);
        @(posedge clk);
        #1 trig_in = 1'b1;
        while (!seen && n < 400) begin
            @(posedge clk);
            n++;
            if (extra_at > 0 && n == extra_at) #1 trig_in = 1'b0;
            if (extra_at > 0 && n == extra_at + 3) #1 trig_in = 1'b1;
            @(negedge clk);
            if (adc_start) seen = 1;
        end
        trig_in = 1'b0;
        check_eq(tag, 32'(n), 32'(lat_q.pop_front()));
    endtask

    task automatic finish_sample(input string tag, input bit give_done);
        int w;
        logic [ADC_W-1:0] v;
        w = 1;
        do begin
            @(negedge clk);
            if (adc_start) w++;
        end while (adc_start && w < 64);
        check_eq(tag, 32'(w), 32'(START_W));
        if (give_done) begin
            v = ADC_W'(samp_n * 1237 + 345);
            samp_n++;
            @(posedge clk);
            #1 adc_data = v;
            adc_done = 1'b1;
            repeat (5) @(posedge clk);
            #1 adc_done = 1'b0;
            mem_m[k_m] = v;
            k_m++;
            acc_m = acc_m + step_m;
            if (acc_m > DMAX) begin
                acc_m = DMAX;
                sat_m = 1;
            end
            if (k_m >= npts_m) begin
                done_m = 1;
                if (cont_m) begin
                    k_m = 0;
                    acc_m = base_m;
                end
            end
            repeat (3) @(posedge clk);
        end
    endtask

    initial begin
        int nb, ns;
        samp_n = 0;
        model_reset();

        // Test 1: reset values, then asynchronous reset while adc_start is high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_adc_start", 32'(adc_start), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_value", rd_value, 32'd0);
        rest = 1'b1;
        send_cmd(4'd4, 28'd0);
        model_start(0);
        fire_trig("t1_lat", 0);
        #1 rest = 1'b0;
        #1;
        check_eq("t1_async_start", 32'(adc_start), 32'd0);
        check_eq("t1_async_busy", 32'(busy), 32'd0);
        check_eq("t1_async_rd", rd_value, 32'd0);
        @(negedge clk);
        rest = 1'b1;
        model_reset();
        read_status("t1_status", 0);

        // Test 2: base=10, step=5, npts=4, single.
        send_cmd(4'd1, 28'd10); base_m = 10;
        send_cmd(4'd2, 28'd5);  step_m = 5;
        send_cmd(4'd3, 28'd4);  npts_m = 4;
        send_cmd(4'd4, 28'd0);  model_start(0);
        for (int i = 0; i < 4; i++) begin
            fire_trig("t2_lat", 0);
            finish_sample("t2_width", 1);
            if (i == 0) read_status("t2_mid_status", 1);
        end
        read_status("t2_status", 0);
        for (int a = 0; a < 4; a++) read_buf("t2_buf", a);

        // Test 3: continuous, npts=2, five triggers.
        send_cmd(4'd3, 28'd2); npts_m = 2;
        send_cmd(4'd4, 28'd1); model_start(1);
        for (int i = 0; i < 5; i++) begin
            fire_trig("t3_lat", 0);
            finish_sample("t3_width", 1);
            if (i == 1) read_status("t3_done_status", 1);
        end
        read_status("t3_run_status", 1);
        send_cmd(4'd5, 28'd0);
        read_status("t3_abort_status", 0);
        read_buf("t3_buf0", 0);
        read_buf("t3_buf1", 1);

        // Test 4: no adc_done -> timeout.
        send_cmd(4'd7, 28'd0);
        send_cmd(4'd4, 28'd0); model_start(0);
        fire_trig("t4_lat", 0);
        finish_sample("t4_width", 0);
        nb = -1;
        ns = -1;
        for (int n = 1; n <= TMO_CYC + 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (nb < 0 && !busy) nb = n;
            if (ns < 0 && rd_value[29]) ns = n;
        end
        check_eq("t4_busy_drop", 32'(nb), 32'(TMO_CYC));
        check_eq("t4_tmo_bit", 32'(ns), 32'(TMO_CYC + 1));
        tmo_m = 1;
        read_status("t4_status", 0);

        // Test 5: delay saturation.
        send_cmd(4'd1, 28'(DMAX - 3)); base_m = DMAX - 3;
        send_cmd(4'd2, 28'd2);         step_m = 2;
        send_cmd(4'd3, 28'd3);         npts_m = 3;
        send_cmd(4'd4, 28'd0);         model_start(0);
        for (int i = 0; i < 3; i++) begin
            fire_trig("t5_lat", 0);
            finish_sample("t5_width", 1);
        end
        read_status("t5_status", 0);
        for (int a = 0; a < 3; a++) read_buf("t5_buf", a);

        // Test 6: extra trigger in DELAY, SET_BASE while busy, ABORT in START.
        send_cmd(4'd1, 28'd20); base_m = 20;
        send_cmd(4'd2, 28'd1);  step_m = 1;
        send_cmd(4'd3, 28'd2);  npts_m = 2;
        send_cmd(4'd4, 28'd0);  model_start(0);
        send_cmd(4'd1, 28'd5);
        fire_trig("t6_lat", 6);
        send_cmd(4'd5, 28'd0);
        @(negedge clk);
        check_eq("t6_abort_start", 32'(adc_start), 32'd0);
        check_eq("t6_abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 trig_in = 1'b1;
        repeat (5) @(posedge clk);
        #1 trig_in = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("t6_idle_trig", 32'(busy), 32'd0);
        send_cmd(4'd4, 28'd0); model_start(0);
        fire_trig("t6_relat", 0);
        finish_sample("t6_width", 1);
        read_status("t6_status", 1);
        send_cmd(4'd5, 28'd0);
        read_buf("t6_buf0", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
